// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_rr_arbiter                                                            |
// | N-master to 1-slave pipelined Wishbone arbiter with round-robin grant,   |
// | outstanding-transaction tracking and a bus-timeout watchdog.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_rr_arbiter #(
  parameter int NUM_MASTERS      = 4,
  parameter int AW               = 32,
  parameter int DW               = 32,
  parameter int CNT_W            = 4,
  parameter int TIMEOUT          = 255,
  parameter bit OPT_ZERO_ON_IDLE = 1'b0
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NUM_MASTERS-1:0]      m_cyc,
  input  logic [NUM_MASTERS-1:0]      m_stb,
  input  logic [NUM_MASTERS-1:0]      m_we,
  input  logic [NUM_MASTERS*AW-1:0]   m_addr,
  input  logic [NUM_MASTERS*DW-1:0]   m_data,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel,
  output logic [NUM_MASTERS-1:0]      m_ack,
  output logic [NUM_MASTERS-1:0]      m_err,
  output logic [NUM_MASTERS-1:0]      m_stall,
  output logic                        o_cyc,
  output logic                        o_stb,
  output logic                        o_we,
  output logic [AW-1:0]               o_addr,
  output logic [DW-1:0]               o_data,
  output logic [DW/8-1:0]             o_sel,
  input  logic                        o_ack,
  input  logic                        o_err,
  input  logic                        o_stall,
  output logic [NUM_MASTERS-1:0]      grant,
  output logic                        timeout_evt
);

  localparam int c_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int c_SW    = DW / 8;
  localparam int c_WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  c_MAX_OUT = '1;
  localparam logic [c_WD_W-1:0] c_WD_LIM  = c_WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0]   r_grant, w_grant_nxt;
  logic [c_IDX_W-1:0]       r_last, w_last_nxt;
  logic [CNT_W-1:0]         r_outst, w_outst_nxt;
  logic [c_WD_W-1:0]        r_wdog, w_wdog_nxt;

  logic [AW-1:0]            w_addr [NUM_MASTERS];
  logic [DW-1:0]            w_data [NUM_MASTERS];
  logic [c_SW-1:0]          w_sel  [NUM_MASTERS];
  logic [c_IDX_W-1:0]       w_pick;
  logic                     w_pick_vld;
  logic                     w_own, w_sat, w_busy, w_tmo, w_inc, w_dec;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign w_addr[gi] = m_addr[gi*AW +: AW];
    assign w_data[gi] = m_data[gi*DW +: DW];
    assign w_sel[gi]  = m_sel[gi*c_SW +: c_SW];
  end

  // Search starts just past the previous owner, so every requester is reached within N-1 grants
  always_comb begin
    logic [c_IDX_W:0]   v_sum;
    logic [c_IDX_W-1:0] v_idx;
    w_pick     = r_last;
    w_pick_vld = 1'b0;
    v_sum      = '0;
    v_idx      = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      v_sum = {1'b0, r_last} + (c_IDX_W+1)'(i);
      if (v_sum >= NUM_MASTERS) v_sum = v_sum - (c_IDX_W+1)'(NUM_MASTERS);
      v_idx = v_sum[c_IDX_W-1:0];
      if (!w_pick_vld && m_cyc[v_idx]) begin
        w_pick_vld = 1'b1;
        w_pick     = v_idx;
      end
    end
  end

  assign w_own  = (r_state == S_OWN);
  assign w_sat  = (r_outst == c_MAX_OUT);
  assign w_busy = (r_outst != '0) && !o_ack && !o_err;
  assign w_tmo  = w_own && (TIMEOUT != 0) && w_busy && (r_wdog == c_WD_LIM);
  assign w_inc  = o_stb && !o_stall;
  assign w_dec  = (o_ack || o_err) && (r_outst != '0);
  assign grant  = r_grant;

  always_comb begin
    o_cyc       = 1'b0;
    o_stb       = 1'b0;
    m_ack       = '0;
    m_err       = '0;
    m_stall     = '1;
    timeout_evt = 1'b0;
    if (OPT_ZERO_ON_IDLE && !w_own) begin
      o_we   = 1'b0;
      o_addr = '0;
      o_data = '0;
      o_sel  = '0;
    end else begin
      o_we   = m_we[r_last];
      o_addr = w_addr[r_last];
      o_data = w_data[r_last];
      o_sel  = w_sel[r_last];
    end
    if (w_own) begin
      o_cyc           = m_cyc[r_last] && !w_tmo;
      o_stb           = m_stb[r_last] && !w_sat && !w_tmo;
      m_stall[r_last] = o_stall || w_sat;
      m_ack[r_last]   = o_ack;
      m_err[r_last]   = o_err || w_tmo;
      timeout_evt     = w_tmo;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_outst_nxt = r_outst;
    w_wdog_nxt  = r_wdog;
    case (r_state)
      S_IDLE: begin
        w_outst_nxt = '0;
        w_wdog_nxt  = '0;
        if (w_pick_vld) begin
          w_state_nxt         = S_OWN;
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_last_nxt          = w_pick;
        end
      end
      S_OWN: begin
        // Owner release, slave error and watchdog expiry all end the cycle; late acks are dropped
        if (!m_cyc[r_last] || o_err || w_tmo) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_outst_nxt = '0;
          w_wdog_nxt  = '0;
        end else begin
          if (w_inc && !w_dec)      w_outst_nxt = r_outst + 1'b1;
          else if (!w_inc && w_dec) w_outst_nxt = r_outst - 1'b1;
          w_wdog_nxt = (w_busy && TIMEOUT != 0) ? r_wdog + 1'b1 : '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= c_LAST_RST;
      r_outst <= '0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_outst <= w_outst_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_rr_arbiter                                                         |
// | Randomized scoreboard bench for wb_rr_arbiter against a cycle model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_rr_arbiter;

  localparam int N       = 4;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int SW      = DW / 8;
  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 8;
  localparam int MAXO    = (1 << CNT_W) - 1;
  localparam int NCYC    = 4000;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_data;
  logic [N*SW-1:0] m_sel;
  logic [N-1:0]    m_ack, m_err, m_stall, grant;
  logic            o_cyc, o_stb, o_we, o_ack, o_err, o_stall, timeout_evt;
  logic [AW-1:0]   o_addr;
  logic [DW-1:0]   o_data;
  logic [SW-1:0]   o_sel;

  always #5 CLK = ~CLK;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .AW(AW), .DW(DW), .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT), .OPT_ZERO_ON_IDLE(1'b0)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_addr(m_addr), .m_data(m_data), .m_sel(m_sel),
    .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
    .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we),
    .o_addr(o_addr), .o_data(o_data), .o_sel(o_sel),
    .o_ack(o_ack), .o_err(o_err), .o_stall(o_stall),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic [N-1:0]  stall;
    logic [N-1:0]  grant;
    logic          tevt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Reference model: owner is -1 when the bus is free
  int owner, last, outst, wcnt, pend;
  bit p_nrst, p_ack, p_err, p_stall, p_ostb, p_tmo;
  logic [N-1:0] p_cyc;

  logic [N-1:0]  want, cyc_v, stb_v, we_v;
  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] data_a [N];
  logic [SW-1:0] sel_a  [N];
  bit ack_i, err_i, stall_i, nrst_i, cur_ostb, cur_tmo;
  int ack_pct, err_pct, stall_pct, drop_pct;

  task automatic model_step();
    int  old_o;
    bit  busy;
    bit  found;
    if (!p_nrst) begin
      owner = -1; last = N - 1; outst = 0; wcnt = 0;
    end else if (owner < 0) begin
      found = 1'b0;
      for (int d = 1; d <= N; d++) begin
        int c;
        c = (last + d) % N;
        if (!found && p_cyc[c]) begin
          found = 1'b1; owner = c; last = c;
        end
      end
      outst = 0; wcnt = 0;
    end else if (!p_cyc[owner] || p_err || p_tmo) begin
      owner = -1; outst = 0; wcnt = 0;
    end else begin
      old_o = outst;
      busy  = (old_o > 0) && !p_ack && !p_err;
      if (p_ostb && !p_stall) outst++;
      if (p_ack && old_o > 0) outst--;
      wcnt = busy ? wcnt + 1 : 0;
    end
  endtask

  task automatic build_expect(output exp_t e);
    int src;
    bit sat;
    e = '0;
    e.stall  = '1;
    cur_ostb = 1'b0;
    cur_tmo  = 1'b0;
    src = (owner >= 0) ? owner : last;
    e.we   = we_v[src];
    e.addr = addr_a[src];
    e.data = data_a[src];
    e.sel  = sel_a[src];
    if (owner >= 0) begin
      sat      = (outst == MAXO);
      cur_tmo  = (outst > 0) && !ack_i && !err_i && (wcnt == TIMEOUT - 1);
      cur_ostb = stb_v[owner] && !sat && !cur_tmo;
      e.cyc          = cyc_v[owner] && !cur_tmo;
      e.stb          = cur_ostb;
      e.stall[owner] = stall_i || sat;
      e.ack[owner]   = ack_i;
      e.err[owner]   = err_i || cur_tmo;
      e.grant[owner] = 1'b1;
      e.tevt         = cur_tmo;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    if (got !== exp) begin
      n_mis++;
      $display("FAIL vec %0d %s: got %0h expected %0h", n_vec, nm, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        chk("o_cyc",       64'(o_cyc),       64'(e.cyc));
        chk("o_stb",       64'(o_stb),       64'(e.stb));
        chk("o_we",        64'(o_we),        64'(e.we));
        chk("o_addr",      64'(o_addr),      64'(e.addr));
        chk("o_data",      64'(o_data),      64'(e.data));
        chk("o_sel",       64'(o_sel),       64'(e.sel));
        chk("m_ack",       64'(m_ack),       64'(e.ack));
        chk("m_err",       64'(m_err),       64'(e.err));
        chk("m_stall",     64'(m_stall),     64'(e.stall));
        chk("grant",       64'(grant),       64'(e.grant));
        chk("timeout_evt", 64'(timeout_evt), 64'(e.tevt));
      end
    end
  end

  initial begin
    exp_t e;
    nRST = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    m_addr = '0; m_data = '0; m_sel = '0;
    o_ack = 1'b0; o_err = 1'b0; o_stall = 1'b0;
    owner = -1; last = N - 1; outst = 0; wcnt = 0; pend = 0;
    p_nrst = 1'b0; p_cyc = '0; p_ack = 1'b0; p_err = 1'b0;
    p_stall = 1'b0; p_ostb = 1'b0; p_tmo = 1'b0;
    want = '0;
    ack_pct = 60; err_pct = 0; stall_pct = 0; drop_pct = 4;

    for (int cn = 0; cn < NCYC; cn++) begin
      @(posedge CLK);
      #1;
      model_step();
      if (!p_nrst) pend = 0;
      else begin
        if (p_ostb && !p_stall) pend++;
        if ((p_ack || p_err) && pend > 0) pend--;
      end

      if (cn > 0 && cn % 400 == 0) begin
        case ($urandom_range(2))
          0: ack_pct = 60;
          1: ack_pct = 25;
          default: ack_pct = 0;
        endcase
        err_pct   = ($urandom_range(1) == 0) ? 0 : 4;
        stall_pct = ($urandom_range(1) == 0) ? 0 : 30;
        drop_pct  = ($urandom_range(1) == 0) ? 4 : 15;
      end

      nrst_i = (cn < 3) ? 1'b0 : ($urandom_range(699) != 0);
      for (int i = 0; i < N; i++) begin
        if (want[i]) want[i] = ($urandom_range(99) >= drop_pct);
        else         want[i] = ($urandom_range(99) < 35);
        cyc_v[i]  = want[i];
        stb_v[i]  = want[i] && ($urandom_range(99) < 60);
        we_v[i]   = $urandom_range(1) != 0;
        addr_a[i] = AW'($urandom);
        data_a[i] = DW'($urandom);
        sel_a[i]  = SW'($urandom);
      end
      stall_i = $urandom_range(99) < stall_pct;
      ack_i   = (pend > 0) && ($urandom_range(99) < ack_pct);
      err_i   = !ack_i && (pend > 0) && ($urandom_range(99) < err_pct);

      nRST = nrst_i; m_cyc = cyc_v; m_stb = stb_v; m_we = we_v;
      for (int i = 0; i < N; i++) begin
        m_addr[i*AW +: AW] = addr_a[i];
        m_data[i*DW +: DW] = data_a[i];
        m_sel[i*SW +: SW]  = sel_a[i];
      end
      o_ack = ack_i; o_err = err_i; o_stall = stall_i;

      build_expect(e);
      q.push_back(e);
      p_nrst = nrst_i; p_cyc = cyc_v; p_ack = ack_i; p_err = err_i;
      p_stall = stall_i; p_ostb = cur_ostb; p_tmo = cur_tmo;
    end

    repeat (3) @(negedge CLK);
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
